// File: rtl/spk_stream_packer.sv
// Spike stream consumer: captures spikes into two ping-pong slots and
// serialises each complete spike as a framed 32-bit packet (valid/ready).
module spk_stream_packer #(
   parameter int unsigned SPK_LENGTH = 19,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spk_valid,
   input  logic [5:0]  spk_ch,
   input  logic [31:0] spk_time,
   input  logic [15:0] spk_dest,
   input  logic [95:0] spk_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic [15:0] drop_cnt,
   output logic [15:0] err_cnt
);
   localparam int unsigned   DEPTH      = 2 * SPK_LENGTH;
   localparam int unsigned   AW         = $clog2(DEPTH);
   localparam int unsigned   IW         = $clog2(SPK_LENGTH);
   localparam logic [15:0]   LAST_DEST  = 16'(SPK_LENGTH - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(SPK_LENGTH - 1);
   localparam logic [AW-1:0] SLOT1_BASE = AW'(SPK_LENGTH);

   typedef enum logic [1:0] {C_IDLE, C_FILL, C_DROP} cap_state_t;
   typedef enum logic [1:0] {O_IDLE, O_HDR, O_TIME, O_DATA} out_state_t;

   cap_state_t    r_cst, w_cst_nxt;
   out_state_t    r_ost, w_ost_nxt;

   logic [95:0]   r_mem [DEPTH];
   logic [5:0]    r_ch [2];
   logic [31:0]   r_time [2];
   logic [1:0]    r_full;
   logic          r_wslot;
   logic          r_rslot;
   logic [15:0]   r_exp;
   logic [IW-1:0] r_oidx;
   logic [1:0]    r_osub;
   logic [15:0]   r_drop_cnt;
   logic [15:0]   r_err_cnt;

   logic          w_free;
   logic          w_start;
   logic          w_store;
   logic          w_commit;
   logic          w_err;
   logic          w_drop;
   logic          w_release;
   logic          w_last;
   logic [1:0]    w_set;
   logic [1:0]    w_clr;
   logic [AW-1:0] w_waddr;
   logic [AW-1:0] w_raddr;
   logic [95:0]   w_rsample;
   logic [31:0]   w_rword;

   // Free status comes from the registered flags, so a slot released this
   // cycle cannot be claimed by a spike starting in the same cycle.
   assign w_free  = ~r_full[r_wslot];
   assign w_waddr = (r_wslot ? SLOT1_BASE : '0) + AW'(spk_dest);
   assign w_raddr = (r_rslot ? SLOT1_BASE : '0) + AW'(r_oidx);
   assign w_rsample = r_mem[w_raddr];
   assign w_last  = (r_oidx == LAST_IDX) && (r_osub == 2'd2);
   assign w_set   = {w_commit & r_wslot, w_commit & ~r_wslot};
   assign w_clr   = {w_release & r_rslot, w_release & ~r_rslot};

   assign drop_cnt = r_drop_cnt;
   assign err_cnt  = r_err_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cst <= C_IDLE;
         r_ost <= O_IDLE;
      end else begin
         r_cst <= w_cst_nxt;
         r_ost <= w_ost_nxt;
      end
   end

   always_comb begin
      w_cst_nxt = r_cst;
      w_start   = 1'b0;
      w_store   = 1'b0;
      w_commit  = 1'b0;
      w_err     = 1'b0;
      w_drop    = 1'b0;
      if (spk_valid) begin
         case (r_cst)
            C_FILL: begin
               if (spk_dest == r_exp) begin
                  w_store = 1'b1;
                  if (spk_dest == LAST_DEST) begin
                     w_commit  = 1'b1;
                     w_cst_nxt = C_IDLE;
                  end
               end else if (spk_dest == '0) begin
                  w_err   = 1'b1;
                  w_start = 1'b1;
                  w_store = 1'b1;
               end else begin
                  w_err     = 1'b1;
                  w_cst_nxt = C_IDLE;
               end
            end
            default: begin
               if (spk_dest == '0) begin
                  if (w_free) begin
                     w_start   = 1'b1;
                     w_store   = 1'b1;
                     w_cst_nxt = C_FILL;
                  end else begin
                     w_drop    = 1'b1;
                     w_cst_nxt = C_DROP;
                  end
               end else if (r_cst == C_IDLE) begin
                  w_err = 1'b1;
               end else if (spk_dest == LAST_DEST) begin
                  w_cst_nxt = C_IDLE;
               end
            end
         endcase
      end
   end

   always_comb begin
      w_rword = w_rsample[31:0];
      case (r_osub)
         2'd0:    w_rword = w_rsample[95:64];
         2'd1:    w_rword = w_rsample[63:32];
         default: w_rword = w_rsample[31:0];
      endcase
   end

   always_comb begin
      w_ost_nxt = r_ost;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      w_release = 1'b0;
      case (r_ost)
         O_IDLE: begin
            if (r_full[r_rslot]) w_ost_nxt = O_HDR;
         end
         O_HDR: begin
            out_valid = 1'b1;
            out_data  = {SYNC_BYTE, 2'b00, r_ch[r_rslot], 16'(SPK_LENGTH)};
            if (out_ready) w_ost_nxt = O_TIME;
         end
         O_TIME: begin
            out_valid = 1'b1;
            out_data  = r_time[r_rslot];
            if (out_ready) w_ost_nxt = O_DATA;
         end
         O_DATA: begin
            out_valid = 1'b1;
            out_data  = w_rword;
            out_last  = w_last;
            if (out_ready && w_last) begin
               w_release = 1'b1;
               w_ost_nxt = O_IDLE;
            end
         end
         default: w_ost_nxt = O_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_full     <= '0;
         r_wslot    <= 1'b0;
         r_rslot    <= 1'b0;
         r_exp      <= '0;
         r_oidx     <= '0;
         r_osub     <= '0;
         r_drop_cnt <= '0;
         r_err_cnt  <= '0;
      end else begin
         r_full <= (r_full | w_set) & ~w_clr;
         if (w_start) r_exp <= 16'd1;
         else if (w_store) r_exp <= r_exp + 16'd1;
         if (w_commit) r_wslot <= ~r_wslot;
         if (w_release) r_rslot <= ~r_rslot;
         if (r_ost != O_DATA) begin
            r_oidx <= '0;
            r_osub <= '0;
         end else if (out_ready) begin
            if (r_osub == 2'd2) begin
               r_osub <= '0;
               r_oidx <= r_oidx + IW'(1);
            end else begin
               r_osub <= r_osub + 2'd1;
            end
         end
         if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 16'd1;
         if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_store) r_mem[w_waddr] <= spk_data;
      if (w_start) begin
         r_ch[r_wslot]   <= spk_ch;
         r_time[r_wslot] <= spk_time;
      end
   end

endmodule

// File: tb/tb_spk_stream_packer.sv
// Bench for spk_stream_packer: queue-based packet model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spk_stream_packer;
   localparam int L  = 19;
   localparam int PL = 2 + 3 * L;
   localparam int M_IDLE = 0, M_FILL = 1, M_DROP = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        spk_valid;
   logic [5:0]  spk_ch;
   logic [31:0] spk_time;
   logic [15:0] spk_dest;
   logic [95:0] spk_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic [15:0] drop_cnt;
   logic [15:0] err_cnt;

   int total = 0;
   int bad   = 0;
   int rmode = 0;

   // behavioural model state
   logic [31:0] exp_q[$];
   int          pkt_commit[$];
   logic [95:0] samp_q[$];
   logic [31:0] dut_log[$];
   int          cyc = 0;
   int          last_rel = -10;
   int          occ = 0;
   int          pos = 0;
   int          m_mode = 0;
   int          m_drop = 0;
   int          m_err = 0;
   logic [5:0]  m_ch;
   logic [31:0] m_time;

   spk_stream_packer #(.SPK_LENGTH(L), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .spk_valid(spk_valid), .spk_ch(spk_ch),
      .spk_time(spk_time), .spk_dest(spk_dest), .spk_data(spk_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      pkt_commit.delete();
      samp_q.delete();
      last_rel = cyc - 10;
      occ = 0; pos = 0; m_mode = M_IDLE; m_drop = 0; m_err = 0;
   endfunction

   function automatic void model_commit();
      logic [95:0] s;
      exp_q.push_back({8'hA5, 2'b00, m_ch, 16'(L)});
      exp_q.push_back(m_time);
      foreach (samp_q[i]) begin
         s = samp_q[i];
         exp_q.push_back(s[95:64]);
         exp_q.push_back(s[63:32]);
         exp_q.push_back(s[31:0]);
      end
      pkt_commit.push_back(cyc);
      occ++;
      samp_q.delete();
      m_mode = M_IDLE;
   endfunction

   function automatic void model_start();
      samp_q.delete();
      samp_q.push_back(spk_data);
      m_ch = spk_ch;
      m_time = spk_time;
   endfunction

   function automatic void model_capture();
      int d;
      d = int'(spk_dest);
      if (!spk_valid) return;
      if (m_mode == M_FILL) begin
         if (d == samp_q.size()) begin
            samp_q.push_back(spk_data);
            if (samp_q.size() == L) model_commit();
         end else if (d == 0) begin
            m_err++;
            model_start();
         end else begin
            m_err++;
            samp_q.delete();
            m_mode = M_IDLE;
         end
      end else if (d == 0) begin
         if (occ < 2) begin
            model_start();
            m_mode = M_FILL;
         end else begin
            m_drop++;
            m_mode = M_DROP;
         end
      end else if (m_mode == M_IDLE) begin
         m_err++;
      end else if (d == L - 1) begin
         m_mode = M_IDLE;
      end
   endfunction

   // single compare process: check outputs, then advance the model one cycle
   always @(negedge clk) begin : model_chk
      bit vis;
      logic [31:0] e_data;
      vis = (pkt_commit.size() != 0) && (cyc >= pkt_commit[0] + 2) && (cyc >= last_rel + 2);
      e_data = vis ? exp_q[0] : 32'h0;
      chk("out_valid", 32'(out_valid), 32'(vis));
      chk("out_last", 32'(out_last), 32'(vis && (pos == PL - 1)));
      if (vis) chk("out_data", out_data, e_data);
      chk("drop_cnt", 32'(drop_cnt), (m_drop > 65535) ? 32'hFFFF : 32'(m_drop));
      chk("err_cnt", 32'(err_cnt), (m_err > 65535) ? 32'hFFFF : 32'(m_err));
      if (out_valid && out_ready) dut_log.push_back(out_data);
      if (rst) begin
         model_reset();
      end else begin
         model_capture();
         if (vis && out_ready) begin
            void'(exp_q.pop_front());
            pos++;
            if (pos == PL) begin
               pos = 0;
               void'(pkt_commit.pop_front());
               last_rel = cyc;
               occ--;
            end
         end
      end
      cyc++;
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic v, input logic [15:0] d, input logic [5:0] ch,
                        input logic [31:0] t, input logic [95:0] dat);
      @(posedge clk); #1;
      spk_valid = v; spk_dest = d; spk_ch = ch; spk_time = t; spk_data = dat;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 16'd0, 6'd0, 32'd0, 96'd0);
   endtask

   // samples 0..n-1, 'gap' idle cycles before every sample but the first
   task automatic send_spike(input logic [5:0] ch, input logic [31:0] t, input int n,
                             input int gap, input bit idx_data);
      logic [95:0] dat;
      for (int i = 0; i < n; i++) begin
         if (i > 0) idle(gap);
         dat = idx_data ? {32'(i), 32'(i), 32'(i)} : {$urandom, $urandom, $urandom};
         drive(1'b1, 16'(i), ch, t, dat);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_mode == M_FILL) && n < 4000) begin
         @(posedge clk);
         n++;
      end
      chk("drain_bound", 32'(n < 4000), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic pulse_rst();
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
   endtask

   initial begin
      int n;
      int kind, k;
      rst = 1'b1; spk_valid = 1'b0; spk_ch = '0; spk_time = '0; spk_dest = '0; spk_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      rst = 1'b0;

      // single spike, index data
      rmode = 0;
      dut_log.delete();
      send_spike(6'd5, 32'd1000, L, 0, 1'b1);
      idle(1);
      drain();
      chk("t1_len", 32'(dut_log.size()), 32'd59);
      chk("t1_hdr", dut_log[0], 32'hA505_0013);
      chk("t1_time", dut_log[1], 32'd1000);
      chk("t1_w3", dut_log[2], 32'd0);
      chk("t1_last", dut_log[58], 32'd18);

      // same spike with out_ready toggling
      rmode = 1;
      dut_log.delete();
      send_spike(6'd5, 32'd1000, L, 0, 1'b1);
      idle(1);
      drain();
      chk("t2_len", 32'(dut_log.size()), 32'd59);
      chk("t2_hdr", dut_log[0], 32'hA505_0013);
      chk("t2_time", dut_log[1], 32'd1000);
      for (int w = 2; w < 59 && w < dut_log.size(); w++)
         chk("t2_word", dut_log[w], 32'((w - 2) / 3));

      // three back-to-back spikes with out_ready low
      rmode = 2;
      dut_log.delete();
      send_spike(6'd1, 32'd11, L, 0, 1'b0);
      send_spike(6'd2, 32'd22, L, 0, 1'b0);
      send_spike(6'd3, 32'd33, L, 0, 1'b0);
      idle(4);
      chk("t3_drop", 32'(drop_cnt), 32'd1);
      chk("t3_nolog", 32'(dut_log.size()), 32'd0);
      rmode = 0;
      drain();
      chk("t3_len", 32'(dut_log.size()), 32'd118);
      chk("t3_hdr0", dut_log[0], 32'hA501_0013);
      chk("t3_hdr1", dut_log[59], 32'hA502_0013);

      // sequence error 0,1,2,4
      dut_log.delete();
      send_spike(6'd4, 32'd44, 3, 0, 1'b0);
      drive(1'b1, 16'd4, 6'd4, 32'd44, 96'd0);
      idle(4);
      chk("t4_err", 32'(err_cnt), 32'd1);
      chk("t4_nopkt", 32'(dut_log.size()), 32'd0);
      send_spike(6'd7, 32'd77, L, 0, 1'b0);
      idle(1);
      drain();
      chk("t4_len", 32'(dut_log.size()), 32'd59);
      chk("t4_hdr", dut_log[0], 32'hA507_0013);

      // reset in the middle of a packet
      dut_log.delete();
      send_spike(6'd8, 32'd88, L, 0, 1'b0);
      idle(1);
      n = 0;
      while (dut_log.size() < 30 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("t5_reach30", 32'(n < 200), 32'd1);
      pulse_rst();
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_drop", 32'(drop_cnt), 32'd0);
      chk("t5_err", 32'(err_cnt), 32'd0);
      dut_log.delete();
      send_spike(6'd9, 32'd555, L, 0, 1'b0);
      idle(1);
      drain();
      chk("t5_len", 32'(dut_log.size()), 32'd59);
      chk("t5_hdr", dut_log[0], 32'hA509_0013);
      chk("t5_time", dut_log[1], 32'd555);

      // gaps between samples, header two cycles after the final sample
      dut_log.delete();
      send_spike(6'd5, 32'd1000, L, 3, 1'b1);
      idle(1);
      chk("t6_n1_valid", 32'(out_valid), 32'd0);
      idle(1);
      chk("t6_n2_valid", 32'(out_valid), 32'd1);
      chk("t6_n2_hdr", out_data, 32'hA505_0013);
      drain();
      chk("t6_len", 32'(dut_log.size()), 32'd59);
      chk("t6_last", dut_log[58], 32'd18);

      // randomized traffic against the model
      rmode = 3;
      for (int s = 0; s < 60; s++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 6) begin
            send_spike(6'($urandom), $urandom, L, $urandom_range(0, 1), 1'b0);
         end else if (kind == 7) begin
            k = $urandom_range(1, 16);
            send_spike(6'($urandom), $urandom, k, 0, 1'b0);
            drive(1'b1, 16'(k + 2), 6'd0, 32'd0, 96'd0);
         end else if (kind == 8) begin
            send_spike(6'($urandom), $urandom, $urandom_range(1, 10), 0, 1'b0);
            send_spike(6'($urandom), $urandom, L, 0, 1'b0);
         end else begin
            drive(1'b1, 16'($urandom_range(1, L - 1)), 6'd0, 32'd0, 96'd0);
         end
         idle($urandom_range(0, 4));
      end
      idle(2);
      rmode = 0;
      drain();

      // error counter saturation
      pulse_rst();
      repeat (65540) drive(1'b1, 16'd1, 6'd0, 32'd0, 96'd0);
      idle(2);
      chk("sat_err", 32'(err_cnt), 32'h0000_FFFF);
      chk("sat_drop", 32'(drop_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
